// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
//   Shared definitions for the uart_tx message arbiter:
//   - arb_state_t : FSM state encoding (ST_IDLE / ST_SEND / ST_DRAIN)
//   - DEFAULT_TIMEOUT_CYCLES : mid-message stall limit (1 ms at 27 MHz)
//   - rr_distance() : round-robin search distance of a requester index
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no owner
    ST_SEND  = 2'd1,  // forwarding bytes from the owner
    ST_DRAIN = 2'd2   // last byte queued, waiting for uart_tx to take it
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 27_000;

  // Position of requester idx in the search order that starts just after
  // last_idx: last_idx+1 -> 0, last_idx+2 -> 1, ..., last_idx -> n-1.
  function automatic int rr_distance(input int idx, input int last_idx, input int n);
    int d;
    d = idx - last_idx - 1;
    if (d < 0) d = d + n;
    return d;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// rr_priority_picker
//   Combinational round-robin picker. The search starts at
//   (last_idx+1) mod N and returns the first requesting index.
// Ports:
//   req      in  N        request vector
//   last_idx in  log2(N)  most recently served index
//   gnt      out N        one-hot winner (all zero when req is all zero)
//   gnt_idx  out log2(N)  binary winner index (valid when |req)
module rr_priority_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_idx,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int IW = $clog2(N);

  logic w_found;

  // Scan distances in increasing order; the first requester found at the
  // smallest distance from last_idx wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!w_found && req[i] && (rr_distance(i, int'(last_idx), N) == k)) begin
          w_found = 1'b1;
          gnt[i]  = 1'b1;
          gnt_idx = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Message-granular round-robin arbiter sharing one uart_tx serializer
//   between NUM_REQ byte-stream requesters. An owner keeps the grant from
//   its first byte through its last byte; a watchdog revokes the grant if
//   the owner stalls mid-message with the output register empty.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req_data           8*NUM_REQ bytes, requester i in [8i+7:8i]
//   req_valid/last     per-requester byte valid / end-of-message
//   req_ready          per-requester byte taken this cycle
//   tx_data/_valid     byte offered to uart_tx
//   tx_data_ready      uart_tx idle and accepting
//   grant              one-hot owner, zero when idle
//   busy               message in progress (state != IDLE)
//   timeout_pulse      one-cycle pulse when the watchdog revokes a grant
//   dbg_state          current FSM state (arb_state_t encoding)
//
// Handshakes (both sides): a byte moves in a cycle where valid and ready
// are both high. valid, once raised, holds with stable data until that
// cycle; ready may be driven from valid-independent state only.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_data_valid,
  input  logic                   tx_data_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   timeout_pulse,
  output logic [1:0]             dbg_state
);

  localparam int IW  = $clog2(NUM_REQ);
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LAST      = WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0]  LAST_IDX_RST = IW'(NUM_REQ - 1);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [IW-1:0]        r_owner;
  logic [IW-1:0]        r_last_grant;
  logic [NUM_REQ-1:0]   r_grant;
  logic [7:0]           r_tx_data;
  logic                 r_tx_valid;
  logic [WDW-1:0]       r_wdog;

  logic [NUM_REQ-1:0]   w_pick_gnt;
  logic [IW-1:0]        w_pick_idx;
  logic                 w_own_valid;
  logic                 w_own_last;
  logic [7:0]           w_own_data;
  logic                 w_take;
  logic                 w_xfer;
  logic                 w_timeout;
  logic                 w_wd_run;
  logic                 w_release;

  rr_priority_picker #(
    .N (NUM_REQ)
  ) u_picker (
    .req      (req_valid),
    .last_idx (r_last_grant),
    .gnt      (w_pick_gnt),
    .gnt_idx  (w_pick_idx)
  );

  // Owner's request lane.
  always_comb begin
    w_own_valid = 1'b0;
    w_own_last  = 1'b0;
    w_own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == IW'(i)) begin
        w_own_valid = req_valid[i];
        w_own_last  = req_last[i];
        w_own_data  = req_data[8*i +: 8];
      end
    end
  end

  assign w_xfer = r_tx_valid & tx_data_ready;

  // Next-state and handshake decode.
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    w_take      = 1'b0;
    w_timeout   = 1'b0;
    w_wd_run    = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|req_valid) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        // Only accept when the output register is empty, so a pending byte
        // is never overwritten.
        for (int i = 0; i < NUM_REQ; i++) begin
          if (r_owner == IW'(i)) req_ready[i] = tx_data_ready & ~r_tx_valid;
        end
        w_take = w_own_valid & tx_data_ready & ~r_tx_valid;
        if (w_take) begin
          if (w_own_last) w_state_nxt = ST_DRAIN;
        end else if (!r_tx_valid && !w_own_valid) begin
          // Watchdog only counts with the output empty and the owner silent.
          if (r_wdog == WD_LAST) begin
            w_timeout   = 1'b1;
            w_release   = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_wd_run = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (w_xfer) begin
          w_release   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= '0;
      r_last_grant <= LAST_IDX_RST;
      r_grant      <= '0;
      r_tx_data    <= 8'h00;
      r_tx_valid   <= 1'b0;
      r_wdog       <= '0;
    end else begin
      if ((r_state == ST_IDLE) && (|req_valid)) begin
        r_grant <= w_pick_gnt;
        r_owner <= w_pick_idx;
        r_wdog  <= '0;
      end
      if (w_take) begin
        r_tx_data  <= w_own_data;
        r_tx_valid <= 1'b1;
        r_wdog     <= '0;
      end else if (w_xfer) begin
        r_tx_valid <= 1'b0;
      end
      if (w_wd_run) r_wdog <= r_wdog + 1'b1;
      if (w_release) begin
        r_last_grant <= r_owner;
        r_grant      <= '0;
        r_wdog       <= '0;
      end
    end
  end

  assign grant         = r_grant;
  assign tx_data       = r_tx_data;
  assign tx_data_valid = r_tx_valid;
  assign busy          = (r_state != ST_IDLE);
  assign timeout_pulse = w_timeout;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Bench for uart_tx_arbiter with two requesters and a 100-cycle watchdog.
//   Requester byte queues feed the DUT; every byte queued is also pushed,
//   in the expected wire order, to exp_q as {last, owner_grant, data}.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 2;
  localparam int TO      = 100;
  localparam int W       = 11;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_data_valid;
  logic                 tx_data_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 timeout_pulse;
  logic [1:0]           dbg_state;

  logic [W-1:0] exp_q[$];
  logic [8:0]   src0_q[$];
  logic [8:0]   src1_q[$];

  int   n_total = 0;
  int   n_bad   = 0;
  logic gap_en      = 1'b0;
  logic ds_rand     = 1'b0;
  logic ds_hold_low = 1'b0;
  logic chk_grant01 = 1'b0;

  uart_tx_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .grant         (grant),
    .busy          (busy),
    .timeout_pulse (timeout_pulse),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / hang guard ----------------
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL global_timeout: sim time exceeded, bad=%0d", n_bad);
    $fatal(1, "hang");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_byte(input int r, input logic [7:0] b, input logic last);
    if (r == 0) src0_q.push_back({last, b});
    else        src1_q.push_back({last, b});
    exp_q.push_back({last, (r == 0) ? 2'b01 : 2'b10, b});
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src0_q.size() != 0 || src1_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_in_budget", 32'(n < budget), 1);
    repeat (2) @(negedge clk);
  endtask

  // Requester model: pop on a handshake seen before the edge, present the
  // queue head just after the edge.
  initial begin : req_driver
    logic [1:0] hs;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      if (hs[0] && src0_q.size() > 0) void'(src0_q.pop_front());
      if (hs[1] && src1_q.size() > 0) void'(src1_q.pop_front());
      req_valid = '0;
      req_last  = '0;
      req_data  = '0;
      if (src0_q.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
        req_valid[0]   = 1'b1;
        req_last[0]    = src0_q[0][8];
        req_data[7:0]  = src0_q[0][7:0];
      end
      if (src1_q.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
        req_valid[1]   = 1'b1;
        req_last[1]    = src1_q[0][8];
        req_data[15:8] = src1_q[0][7:0];
      end
    end
  end

  // uart_tx model on the ready side.
  initial begin : ds_driver
    tx_data_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ds_hold_low)  tx_data_ready = 1'b0;
      else if (ds_rand) tx_data_ready = ($urandom_range(0, 2) != 0);
      else              tx_data_ready = 1'b1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin : monitor
    logic [W-1:0] e;
    logic after_last, prev_valid, prev_xfer, prev_acc;
    logic [7:0] prev_data;
    after_last = 1'b0; prev_valid = 1'b0; prev_xfer = 1'b0; prev_acc = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        after_last = 1'b0; prev_valid = 1'b0; prev_xfer = 1'b0; prev_acc = 1'b0;
      end else begin
        if (after_last) check_eq("busy_after_last", 32'(busy), 0);
        after_last = 1'b0;
        if (prev_acc) check_eq("valid_after_accept", 32'(tx_data_valid), 1);
        if (prev_valid && !prev_xfer && tx_data_valid)
          check_eq("tx_data_stable", 32'(tx_data), 32'(prev_data));
        check_eq("ready_owner_only", 32'(req_ready & ~grant), 0);
        if (chk_grant01 && busy) check_eq("grant_single", 32'(grant), 1);
        if (tx_data_valid && tx_data_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_byte", 32'(tx_data), 32'h100);
          end else begin
            e = exp_q.pop_front();
            check_eq("tx_byte", 32'(tx_data), 32'(e[7:0]));
            check_eq("tx_owner", 32'(grant), 32'(e[9:8]));
            after_last = e[10];
          end
        end
        prev_acc   = |(req_valid & req_ready);
        prev_valid = tx_data_valid;
        prev_xfer  = tx_data_valid & tx_data_ready;
        prev_data  = tx_data;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int n;
    int cnt;
    int r;
    int len;

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_grant",     32'(grant), 0);
    check_eq("rst_busy",      32'(busy), 0);
    check_eq("rst_tx_data",   32'(tx_data), 0);
    check_eq("rst_tx_valid",  32'(tx_data_valid), 0);
    check_eq("rst_req_ready", 32'(req_ready), 0);
    check_eq("rst_timeout",   32'(timeout_pulse), 0);
    check_eq("rst_state",     32'(dbg_state), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // contention from reset: AAA then BBB, twice
    ds_rand = 1'b1;
    repeat (2) begin
      for (int k = 0; k < 3; k++) push_byte(0, 8'h41, k == 2);
      for (int k = 0; k < 3; k++) push_byte(1, 8'h42, k == 2);
      wait_idle(400);
    end
    ds_rand = 1'b0;

    // single message "Hi\r\n" from requester 0
    chk_grant01 = 1'b1;
    push_byte(0, 8'h48, 1'b0);
    push_byte(0, 8'h69, 1'b0);
    push_byte(0, 8'h0D, 1'b0);
    push_byte(0, 8'h0A, 1'b1);
    n = 0;
    while (!req_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_seen", 32'(n < 20), 1);
    check_eq("grant_at_n", 32'(grant), 0);
    @(negedge clk);
    check_eq("grant_at_n1", 32'(grant), 1);
    check_eq("ready_at_n1", 32'(req_ready), 1);
    wait_idle(200);
    chk_grant01 = 1'b0;

    // owner stall with slow downstream, then watchdog
    push_byte(1, 8'h53, 1'b0);
    push_byte(1, 8'h54, 1'b0);
    n = 0;
    while (!(req_valid[1] && req_ready[1] && req_data[15:8] == 8'h54) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("stall_t_accept", 32'(n < 50), 1);
    ds_hold_low = 1'b1;
    push_byte(0, 8'h4F, 1'b0);
    push_byte(0, 8'h4B, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_eq("slow_tx_data",  32'(tx_data), 32'h54);
      check_eq("slow_tx_valid", 32'(tx_data_valid), 1);
      check_eq("slow_req_ready", 32'(req_ready), 0);
      check_eq("slow_timeout",  32'(timeout_pulse), 0);
    end
    ds_hold_low = 1'b0;
    n = 0;
    while (!(tx_data_valid && tx_data_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("stall_t_xfer", 32'(n < 20), 1);
    cnt = 0;
    @(negedge clk);
    while (!timeout_pulse && cnt < 300) begin
      cnt++;
      @(negedge clk);
    end
    check_eq("timeout_delay", 32'(cnt), 99);
    check_eq("timeout_grant_held", 32'(grant), 2);
    @(negedge clk);
    check_eq("timeout_one_cycle", 32'(timeout_pulse), 0);
    check_eq("timeout_grant_clr", 32'(grant), 0);
    check_eq("timeout_busy_clr",  32'(busy), 0);
    @(negedge clk);
    check_eq("pending_grant", 32'(grant), 1);
    wait_idle(200);

    // random single-requester messages with gaps and random ready
    gap_en  = 1'b1;
    ds_rand = 1'b1;
    for (int m = 0; m < 8; m++) begin
      r   = $urandom_range(0, 1);
      len = $urandom_range(1, 5);
      for (int k = 0; k < len; k++) push_byte(r, 8'($urandom_range(0, 255)), k == len - 1);
      wait_idle(500);
    end
    gap_en  = 1'b0;
    ds_rand = 1'b0;

    // reset mid-message with a pending byte
    push_byte(0, 8'h52, 1'b0);
    push_byte(0, 8'h53, 1'b0);
    push_byte(0, 8'h54, 1'b1);
    n = 0;
    while (!(req_valid[0] && req_ready[0]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_test_accept", 32'(n < 50), 1);
    ds_hold_low = 1'b1;
    @(posedge clk);
    #3;
    check_eq("pre_rst_valid", 32'(tx_data_valid), 1);
    check_eq("pre_rst_data",  32'(tx_data), 32'h52);
    rst_n = 1'b0;
    #1;
    check_eq("arst_grant",     32'(grant), 0);
    check_eq("arst_busy",      32'(busy), 0);
    check_eq("arst_tx_data",   32'(tx_data), 0);
    check_eq("arst_tx_valid",  32'(tx_data_valid), 0);
    check_eq("arst_req_ready", 32'(req_ready), 0);
    check_eq("arst_timeout",   32'(timeout_pulse), 0);
    check_eq("arst_state",     32'(dbg_state), 0);
    src0_q.delete();
    src1_q.delete();
    exp_q.delete();
    ds_hold_low = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_byte(0, 8'h61, 1'b1);
    push_byte(1, 8'h62, 1'b1);
    wait_idle(100);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
